// File: rtl/regctl_pkg.sv
// Shared constants and the writeback entry type for the register access controller.
// No logic; imported by the FIFO and the top.
// No flow control here.
package regctl_pkg;

    localparam int NREG = 16;
    localparam int RAW  = 4;
    localparam int DW   = 32;

    typedef struct packed {
        logic [RAW-1:0] addr;
        logic [DW-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/regctl_wb_fifo.sv
// Writeback FIFO: holds ALU or memory results until the arbiter grants the bank port.
// Latency: a push is visible at head the cycle after the push edge.
// Backpressure: full is count based; a push into a full FIFO is dropped even with a same-cycle pop.
import regctl_pkg::*;

module regctl_wb_fifo #(
    parameter int WB_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_dat,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(WB_DEPTH);

    wb_entry_t     mem [WB_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(WB_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap on their own because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/reg_access_ctl.sv
// Register-file access controller: round-robin writeback of ALU/memory results, scoreboarded operand fetch.
// Latency: writeback push -> bank write next cycle; operand accept -> op_a/op_b registered at the accept edge.
// Backpressure: wbX_ready = FIFO not full; rd_req_ready drops on hazard or held operands. Optional REGCTL_FWD_EN.
import regctl_pkg::*;

module reg_access_ctl #(
    parameter int WB_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [3:0]    rd_ra1,
    input  logic [3:0]    rd_ra2,
    input  logic [3:0]    rd_dst,
    input  logic          rd_dst_en,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [31:0]   op_a,
    output logic [31:0]   op_b,
    input  logic          wba_valid,
    output logic          wba_ready,
    input  logic [3:0]    wba_addr,
    input  logic [31:0]   wba_data,
    input  logic          wbb_valid,
    output logic          wbb_ready,
    input  logic [3:0]    wbb_addr,
    input  logic [31:0]   wbb_data,
    output logic [3:0]    rb_ra1,
    output logic [3:0]    rb_ra2,
    input  logic [31:0]   rb_rd1,
    input  logic [31:0]   rb_rd2,
    output logic          rb_w_en,
    output logic [3:0]    rb_wa,
    output logic [31:0]   rb_wd
);

    wb_entry_t       a_head, b_head;
    logic            a_full, a_empty, b_full, b_empty;
    logic            grant_a, grant_b;
    logic            last_b;
    logic [NREG-1:0] busy, busy_nxt;
    logic            fwd1, fwd2;
    logic            hazard;
    logic            accept;

    assign rb_ra1 = rd_ra1;
    assign rb_ra2 = rd_ra2;

    assign wba_ready = ~a_full;
    assign wbb_ready = ~b_full;

    regctl_wb_fifo #(.WB_DEPTH(WB_DEPTH)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .push     (wba_valid & wba_ready),
        .push_dat ({wba_addr, wba_data}),
        .pop      (grant_a),
        .full     (a_full),
        .empty    (a_empty),
        .head     (a_head)
    );

    regctl_wb_fifo #(.WB_DEPTH(WB_DEPTH)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .push     (wbb_valid & wbb_ready),
        .push_dat ({wbb_addr, wbb_data}),
        .pop      (grant_b),
        .full     (b_full),
        .empty    (b_empty),
        .head     (b_head)
    );

    // last_b resets high so A wins the first tie.
    always_comb begin
        grant_a = ~a_empty & (b_empty | last_b);
        grant_b = ~b_empty & (a_empty | ~last_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_b <= 1'b1;
        else if (rb_w_en) last_b <= grant_b;
    end

    always_comb begin
        rb_w_en = 1'b0;
        rb_wa   = '0;
        rb_wd   = '0;
        if (grant_a) begin
            rb_w_en = 1'b1;
            rb_wa   = a_head.addr;
            rb_wd   = a_head.data;
        end else if (grant_b) begin
            rb_w_en = 1'b1;
            rb_wa   = b_head.addr;
            rb_wd   = b_head.data;
        end
    end

`ifdef REGCTL_FWD_EN
    assign fwd1 = rb_w_en & (rb_wa == rd_ra1);
    assign fwd2 = rb_w_en & (rb_wa == rd_ra2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // A forwarded source is never stale; WAW still waits for the old write to land.
    assign hazard = (busy[rd_ra1] & ~fwd1)
                  | (busy[rd_ra2] & ~fwd2)
                  | (rd_dst_en & busy[rd_dst]);

    assign rd_req_ready = (~op_valid | op_ready) & ~hazard;
    assign accept       = rd_req_valid & rd_req_ready;

    // Set is applied after clear so a same-cycle reservation survives the commit.
    always_comb begin
        busy_nxt = busy;
        if (rb_w_en)             busy_nxt[rb_wa]  = 1'b0;
        if (accept && rd_dst_en) busy_nxt[rd_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= fwd1 ? rb_wd : rb_rd1;
            op_b     <= fwd2 ? rb_wd : rb_rd2;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_access_ctl.sv
// Bench for reg_access_ctl: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_access_ctl;

`ifdef REGCTL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req_valid = 1'b0, rd_dst_en = 1'b0, op_ready = 1'b1;
    logic [3:0]  rd_ra1 = '0, rd_ra2 = '0, rd_dst = '0;
    logic        wba_valid = 1'b0, wbb_valid = 1'b0;
    logic [3:0]  wba_addr = '0, wbb_addr = '0;
    logic [31:0] wba_data = '0, wbb_data = '0;
    logic        rd_req_ready, op_valid, wba_ready, wbb_ready, rb_w_en;
    logic [31:0] op_a, op_b, rb_rd1, rb_rd2, rb_wd;
    logic [3:0]  rb_ra1, rb_ra2, rb_wa;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_access_ctl #(.WB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_ra1(rd_ra1), .rd_ra2(rd_ra2), .rd_dst(rd_dst), .rd_dst_en(rd_dst_en),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .wba_valid(wba_valid), .wba_ready(wba_ready), .wba_addr(wba_addr), .wba_data(wba_data),
        .wbb_valid(wbb_valid), .wbb_ready(wbb_ready), .wbb_addr(wbb_addr), .wbb_data(wbb_data),
        .rb_ra1(rb_ra1), .rb_ra2(rb_ra2), .rb_rd1(rb_rd1), .rb_rd2(rb_rd2),
        .rb_w_en(rb_w_en), .rb_wa(rb_wa), .rb_wd(rb_wd)
    );

    // Register bank environment: combinational read, write at the edge.
    logic [31:0] bank [16];
    assign rb_rd1 = bank[rb_ra1];
    assign rb_rd2 = bank[rb_ra2];
    always @(posedge clk) if (rb_w_en) bank[rb_wa] <= rb_wd;

    // Reference model state.
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    bit          pend [16];
    logic [31:0] mreg [16];
    bit          m_opv = 0;
    logic [31:0] m_opa = '0, m_opb = '0;
    bit          m_lastb = 1;

    bit          e_wen, e_pick_a, e_rdy, e_ardy, e_brdy, e_fwd1, e_fwd2;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;

    initial begin
        for (int i = 0; i < 16; i++) begin
            bank[i] = 32'h1000 + i;
            mreg[i] = 32'h1000 + i;
            pend[i] = 0;
        end
    end

    task automatic eval();
        logic [35:0] ent;
        bit haz;
        e_ardy = qa.size() < DEPTH;
        e_brdy = qb.size() < DEPTH;
        e_wen  = (qa.size() != 0) || (qb.size() != 0);
        if (qa.size() != 0 && qb.size() != 0) e_pick_a = m_lastb;
        else                                  e_pick_a = (qa.size() != 0);
        ent = '0;
        if (e_wen) ent = e_pick_a ? qa[0] : qb[0];
        e_wa = ent[35:32];
        e_wd = ent[31:0];
        e_fwd1 = FWD && e_wen && (e_wa == rd_ra1);
        e_fwd2 = FWD && e_wen && (e_wa == rd_ra2);
        haz = (pend[rd_ra1] && !e_fwd1) || (pend[rd_ra2] && !e_fwd2) || (rd_dst_en && pend[rd_dst]);
        e_rdy = (!m_opv || op_ready) && !haz;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 16; i++) pend[i] = 0;
            m_opv = 0; m_opa = '0; m_opb = '0; m_lastb = 1;
        end else begin
            bit acc;
            eval();
            acc = rd_req_valid && e_rdy;
            if (acc) begin
                m_opv = 1;
                m_opa = e_fwd1 ? e_wd : mreg[rd_ra1];
                m_opb = e_fwd2 ? e_wd : mreg[rd_ra2];
            end else if (op_ready) begin
                m_opv = 0;
            end
            if (e_wen) begin
                mreg[e_wa] = e_wd;
                pend[e_wa] = 0;
                if (e_pick_a) void'(qa.pop_front());
                else          void'(qb.pop_front());
                m_lastb = !e_pick_a;
            end
            if (acc && rd_dst_en) pend[rd_dst] = 1;
            if (wba_valid && e_ardy) qa.push_back({wba_addr, wba_data});
            if (wbb_valid && e_brdy) qb.push_back({wbb_addr, wbb_data});
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        eval();
        cmp("rd_req_ready", 32'(rd_req_ready), 32'(e_rdy));
        cmp("op_valid",     32'(op_valid),     32'(m_opv));
        cmp("op_a",         op_a,              m_opa);
        cmp("op_b",         op_b,              m_opb);
        cmp("rb_w_en",      32'(rb_w_en),      32'(e_wen));
        cmp("rb_wa",        32'(rb_wa),        32'(e_wa));
        cmp("rb_wd",        rb_wd,             e_wd);
        cmp("wba_ready",    32'(wba_ready),    32'(e_ardy));
        cmp("wbb_ready",    32'(wbb_ready),    32'(e_brdy));
        cmp("rb_ra1",       32'(rb_ra1),       32'(rd_ra1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_wa [4];
        exp_wa[0] = 4'd8; exp_wa[1] = 4'd12; exp_wa[2] = 4'd9; exp_wa[3] = 4'd13;

        #1 rst = 1'b1;
        tick(); tick();
        #2;
        cmp("reset op_valid", 32'(op_valid), 32'd0);
        cmp("reset rb_w_en", 32'(rb_w_en), 32'd0);
        cmp("reset wba_ready", 32'(wba_ready), 32'd1);
        cmp("reset op_a", op_a, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic writeback then read.
        wba_valid = 1; wba_addr = 4'd3; wba_data = 32'h55;
        tick();
        wba_valid = 0;
        #2;
        cmp("basic rb_w_en", 32'(rb_w_en), 32'd1);
        cmp("basic rb_wa", 32'(rb_wa), 32'd3);
        cmp("basic rb_wd", rb_wd, 32'h55);
        tick();
        rd_req_valid = 1; rd_ra1 = 4'd3; rd_ra2 = 4'd0;
        #2 cmp("basic rd_req_ready", 32'(rd_req_ready), 32'd1);
        tick();
        rd_req_valid = 0;
        #2;
        cmp("basic op_valid", 32'(op_valid), 32'd1);
        cmp("basic op_a", op_a, 32'h55);

        // RAW on register 5.
        tick();
        rd_req_valid = 1; rd_ra1 = 4'd0; rd_dst = 4'd5; rd_dst_en = 1;
        tick();
        rd_ra1 = 4'd5; rd_dst_en = 0;
        #2 cmp("raw stall", 32'(rd_req_ready), 32'd0);
        wbb_valid = 1; wbb_addr = 4'd5; wbb_data = 32'hA0;
        tick();
        wbb_valid = 0;
        #2;
        if (FWD) begin
            cmp("raw fwd commit-cycle ready", 32'(rd_req_ready), 32'd1);
            tick();
            rd_req_valid = 0;
            #2 cmp("raw fwd op_a", op_a, 32'hA0);
        end else begin
            cmp("raw commit-cycle stall", 32'(rd_req_ready), 32'd0);
            tick();
            #2 cmp("raw post-commit ready", 32'(rd_req_ready), 32'd1);
            tick();
            rd_req_valid = 0;
            #2 cmp("raw op_a", op_a, 32'hA0);
        end

        // Arbitration and FIFO full.
        for (int i = 0; i < 4; i++) begin
            wba_valid = 1; wba_addr = 4'(8 + i);  wba_data = 32'hA000_0000 + i;
            wbb_valid = 1; wbb_addr = 4'(12 + i); wbb_data = 32'hB000_0000 + i;
            tick();
            #2 cmp("arb grant addr", 32'(rb_wa), 32'(exp_wa[i]));
            if (i == 1) cmp("arb wbb_ready full", 32'(wbb_ready), 32'd0);
            if (i == 2) cmp("arb wba_ready full", 32'(wba_ready), 32'd0);
        end
        wba_valid = 0; wbb_valid = 0;
        repeat (6) tick();

        // Backpressure.
        op_ready = 0; rd_req_valid = 1; rd_ra1 = 4'd1; rd_ra2 = 4'd2; rd_dst_en = 0;
        tick();
        rd_ra1 = 4'd4; rd_ra2 = 4'd6;
        #2;
        cmp("bp stall", 32'(rd_req_ready), 32'd0);
        cmp("bp op_a", op_a, 32'h1001);
        cmp("bp op_b", op_b, 32'h1002);
        tick();
        #2 cmp("bp op_a held", op_a, 32'h1001);
        op_ready = 1;
        #1 cmp("bp release ready", 32'(rd_req_ready), 32'd1);
        tick();
        rd_req_valid = 0;
        #2;
        cmp("bp next op_a", op_a, 32'h1004);
        cmp("bp next op_b", op_b, 32'h1006);

        // WAW on register 7.
        tick();
        rd_req_valid = 1; rd_ra1 = 4'd0; rd_ra2 = 4'd0; rd_dst = 4'd7; rd_dst_en = 1;
        tick();
        #2 cmp("waw stall", 32'(rd_req_ready), 32'd0);
        wba_valid = 1; wba_addr = 4'd7; wba_data = 32'h77;
        tick();
        wba_valid = 0;
        #2;
        cmp("waw commit wa", 32'(rb_wa), 32'd7);
        cmp("waw commit-cycle stall", 32'(rd_req_ready), 32'd0);
        tick();
        #2 cmp("waw ready after commit", 32'(rd_req_ready), 32'd1);
        tick();
        rd_req_valid = 0; rd_dst_en = 0;

        // Reset with loaded FIFOs.
        tick();
        wba_valid = 1; wba_addr = 4'd2; wba_data = 32'h2A;
        wbb_valid = 1; wbb_addr = 4'd2; wbb_data = 32'h2B;
        tick(); tick();
        wba_valid = 0; wbb_valid = 0;
        #1 rst = 1'b1;
        #1;
        cmp("midrst rb_w_en", 32'(rb_w_en), 32'd0);
        cmp("midrst wba_ready", 32'(wba_ready), 32'd1);
        cmp("midrst wbb_ready", 32'(wbb_ready), 32'd1);
        cmp("midrst op_valid", 32'(op_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #2 cmp("post-reset no write", 32'(rb_w_en), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
